// File: rtl/evif_pkg.sv
// Shared encodings for the event interface: word types, arbiter FSM states
// and the filler word written when a block is cut short.
package evif_pkg;

  localparam logic [1:0] EVT_DATA = 2'b00;
  localparam logic [1:0] EVT_HDR  = 2'b01;
  localparam logic [1:0] EVT_END  = 2'b10;
  localparam logic [1:0] EVT_ERR  = 2'b11;

  localparam logic [15:0] TRUNC_WORD = 16'hDEAD;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_XFER  = 3'd1,
    ST_TRUNC = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RST   = 3'd4
  } state_e;

endpackage

// File: rtl/evif_rr_arbiter.sv
// Combinational round-robin search: returns the first requesting channel at
// or after the pointer, wrapping around, plus a flag saying one was found.
module evif_rr_arbiter #(
  parameter int NCH = 4,
  parameter int GW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req_i,
  input  logic [GW-1:0]  ptr_i,
  output logic [GW-1:0]  idx_o,
  output logic           found_o
);

  // Walk the channels starting at the pointer; the first hit wins.
  always_comb begin
    int j;
    j       = 0;
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      j = int'(ptr_i) + i;
      if (j >= NCH) j = j - NCH;
      if (!found_o && req_i[j]) begin
        found_o = 1'b1;
        idx_o   = GW'(j);
      end
    end
  end

endmodule

// File: rtl/evif_block_arbiter.sv
// Merges NCH event sources into one FIFO write port, one whole block at a
// time, truncating runaway blocks and handling the readout reset handshake.
module evif_block_arbiter #(
  parameter int              NCH        = 4,
  parameter int              DW         = 16,
  parameter int              TW         = 2,
  parameter int              MAX_WORDS  = 1024,
  parameter logic [DW-1:0]   TRUNC_WORD = DW'(evif_pkg::TRUNC_WORD)
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [NCH-1:0]                 src_valid_i,
  input  logic [NCH*DW-1:0]              src_dat_i,
  input  logic [NCH*TW-1:0]              src_type_i,
  output logic [NCH-1:0]                 src_ready_o,
  input  logic                           fifo_full_i,
  output logic                           fifo_wr_o,
  output logic [DW-1:0]                  fifo_dat_o,
  output logic [TW-1:0]                  fifo_type_o,
  output logic                           fifo_block_done_o,
  output logic [$clog2(MAX_WORDS+1)-1:0] blk_len_o,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] grant_o,
  output logic [15:0]                    drop_cnt_o,
  output logic [15:0]                    trunc_cnt_o,
  input  logic                           rst_req_i,
  output logic                           rst_ack_o,
  output logic                           fifo_rst_o
);

  import evif_pkg::*;

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(MAX_WORDS + 1);

  function automatic logic [3:0] popcnt(input logic [NCH-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NCH; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] n);
    logic [16:0] s;
    s = {1'b0, a} + {13'b0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  state_e          state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   blk_len_q, blk_len_d;
  logic            fifo_wr_q, fifo_wr_d;
  logic [DW-1:0]   fifo_dat_q, fifo_dat_d;
  logic [TW-1:0]   fifo_type_q, fifo_type_d;
  logic            done_q, done_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic [15:0]     trunc_cnt_q, trunc_cnt_d;
  logic            fifo_rst_q, fifo_rst_d;
  logic            rst_ack_q, rst_ack_d;

  logic [NCH-1:0]  ready;
  logic [NCH-1:0]  hdr_req;
  logic [NCH-1:0]  stray;
  logic [GW-1:0]   arb_idx;
  logic            arb_found;
  logic [DW-1:0]   arb_dat;
  logic            g_valid;
  logic [DW-1:0]   g_dat;
  logic [TW-1:0]   g_type;
  logic [GW-1:0]   ptr_next;
  logic [CW-1:0]   count_inc;

  // Classify each channel's presented word as a block start or a stray.
  always_comb begin
    hdr_req = '0;
    stray   = '0;
    for (int k = 0; k < NCH; k++) begin
      hdr_req[k] = src_valid_i[k] && (src_type_i[k*TW +: TW] == TW'(EVT_HDR));
      stray[k]   = src_valid_i[k] && (src_type_i[k*TW +: TW] != TW'(EVT_HDR));
    end
  end

  evif_rr_arbiter #(
    .NCH (NCH),
    .GW  (GW)
  ) u_rr (
    .req_i   (hdr_req),
    .ptr_i   (ptr_q),
    .idx_o   (arb_idx),
    .found_o (arb_found)
  );

  // Select the granted and the newly arbitrated channel's words.
  always_comb begin
    arb_dat   = src_dat_i[int'(arb_idx)*DW +: DW];
    g_valid   = src_valid_i[grant_q];
    g_dat     = src_dat_i[int'(grant_q)*DW +: DW];
    g_type    = src_type_i[int'(grant_q)*TW +: TW];
    ptr_next  = (int'(grant_q) == NCH - 1) ? '0 : grant_q + 1'b1;
    count_inc = count_q + CW'(1);
  end

  // Next-state, handshake and write-port logic of the block FSM.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    count_d     = count_q;
    blk_len_d   = blk_len_q;
    fifo_wr_d   = 1'b0;
    fifo_dat_d  = fifo_dat_q;
    fifo_type_d = fifo_type_q;
    done_d      = 1'b0;
    drop_cnt_d  = drop_cnt_q;
    trunc_cnt_d = trunc_cnt_q;
    ready       = '0;

    case (state_q)
      ST_IDLE: begin
        if (rst_req_i) begin
          state_d = ST_RST;
        end else begin
          // Strays are swallowed whether or not the FIFO has room.
          ready      = stray;
          drop_cnt_d = sat_add16(drop_cnt_q, popcnt(stray));
          if (arb_found && !fifo_full_i) begin
            ready[arb_idx] = 1'b1;
            grant_d        = arb_idx;
            count_d        = CW'(1);
            fifo_wr_d      = 1'b1;
            fifo_dat_d     = arb_dat;
            fifo_type_d    = TW'(EVT_HDR);
            state_d        = ST_XFER;
          end
        end
      end

      ST_XFER: begin
        ready[grant_q] = !fifo_full_i;
        if (g_valid && !fifo_full_i) begin
          fifo_wr_d   = 1'b1;
          fifo_dat_d  = g_dat;
          count_d     = count_inc;
          // A header inside a block means the source lost framing.
          fifo_type_d = (g_type == TW'(EVT_HDR)) ? TW'(EVT_ERR) : g_type;
          if (g_type == TW'(EVT_END)) begin
            done_d    = 1'b1;
            blk_len_d = count_inc;
            ptr_d     = ptr_next;
            state_d   = rst_req_i ? ST_RST : ST_IDLE;
          end else if (count_inc == CW'(MAX_WORDS - 1)) begin
            // Leave one slot for the ERR marker.
            state_d = ST_TRUNC;
          end
        end
      end

      ST_TRUNC: begin
        if (!fifo_full_i) begin
          fifo_wr_d   = 1'b1;
          fifo_dat_d  = TRUNC_WORD;
          fifo_type_d = TW'(EVT_ERR);
          done_d      = 1'b1;
          blk_len_d   = CW'(MAX_WORDS);
          trunc_cnt_d = sat_add16(trunc_cnt_q, 4'd1);
          state_d     = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        ready[grant_q] = 1'b1;
        if (g_valid && (g_type == TW'(EVT_END))) begin
          ptr_d   = ptr_next;
          state_d = rst_req_i ? ST_RST : ST_IDLE;
        end
      end

      ST_RST: begin
        if (!rst_req_i) begin
          ptr_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    fifo_rst_d = (state_d == ST_RST) && (state_q != ST_RST);
    rst_ack_d  = (state_d == ST_RST);
  end

  // State, counters and registered write port; everything clears on reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      count_q     <= '0;
      blk_len_q   <= '0;
      fifo_wr_q   <= 1'b0;
      fifo_dat_q  <= '0;
      fifo_type_q <= '0;
      done_q      <= 1'b0;
      drop_cnt_q  <= '0;
      trunc_cnt_q <= '0;
      fifo_rst_q  <= 1'b0;
      rst_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      count_q     <= count_d;
      blk_len_q   <= blk_len_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_dat_q  <= fifo_dat_d;
      fifo_type_q <= fifo_type_d;
      done_q      <= done_d;
      drop_cnt_q  <= drop_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
      fifo_rst_q  <= fifo_rst_d;
      rst_ack_q   <= rst_ack_d;
    end
  end

  // Nothing is accepted while reset is held.
  assign src_ready_o       = rst_n_i ? ready : '0;
  assign fifo_wr_o         = fifo_wr_q;
  assign fifo_dat_o        = fifo_dat_q;
  assign fifo_type_o       = fifo_type_q;
  assign fifo_block_done_o = done_q;
  assign blk_len_o         = blk_len_q;
  assign grant_o           = grant_q;
  assign drop_cnt_o        = drop_cnt_q;
  assign trunc_cnt_o       = trunc_cnt_q;
  assign rst_ack_o         = rst_ack_q;
  assign fifo_rst_o        = fifo_rst_q;

endmodule

// File: tb/tb_evif_block_arbiter.sv
// Directed bench for evif_block_arbiter (NCH=4, MAX_WORDS=8).
module tb_evif_block_arbiter;

  localparam logic [1:0] T_DATA = 2'b00;
  localparam logic [1:0] T_HDR  = 2'b01;
  localparam logic [1:0] T_END  = 2'b10;
  localparam logic [1:0] T_ERR  = 2'b11;

  logic        clk;
  logic        rst_n;
  logic [3:0]  src_valid;
  logic [63:0] src_dat;
  logic [7:0]  src_type;
  logic [3:0]  src_ready;
  logic        fifo_full;
  logic        fifo_wr;
  logic [15:0] fifo_dat;
  logic [1:0]  fifo_type;
  logic        blk_done;
  logic [3:0]  blk_len;
  logic [1:0]  grant;
  logic [15:0] drop_cnt;
  logic [15:0] trunc_cnt;
  logic        rst_req;
  logic        rst_ack;
  logic        fifo_rst;

  int n_checks = 0;
  int n_fail   = 0;

  evif_block_arbiter #(
    .NCH        (4),
    .DW         (16),
    .TW         (2),
    .MAX_WORDS  (8),
    .TRUNC_WORD (16'hDEAD)
  ) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .src_valid_i       (src_valid),
    .src_dat_i         (src_dat),
    .src_type_i        (src_type),
    .src_ready_o       (src_ready),
    .fifo_full_i       (fifo_full),
    .fifo_wr_o         (fifo_wr),
    .fifo_dat_o        (fifo_dat),
    .fifo_type_o       (fifo_type),
    .fifo_block_done_o (blk_done),
    .blk_len_o         (blk_len),
    .grant_o           (grant),
    .drop_cnt_o        (drop_cnt),
    .trunc_cnt_o       (trunc_cnt),
    .rst_req_i         (rst_req),
    .rst_ack_o         (rst_ack),
    .fifo_rst_o        (fifo_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int ch, input logic v, input logic [1:0] ty, input logic [15:0] d);
    src_valid[ch]          = v;
    src_type[ch*2 +: 2]    = ty;
    src_dat[ch*16 +: 16]   = d;
  endtask

  // Present one word, check the readies, clock it and check the write.
  task automatic word(input string tag, input int ch, input logic [1:0] ty,
                      input logic [15:0] d, input logic [3:0] rdy,
                      input logic [1:0] oty, input logic done);
    set_w(ch, 1'b1, ty, d);
    #1;
    chk({tag, "_rdy"}, 32'(src_ready), 32'(rdy));
    tick();
    chk({tag, "_wr"},   32'(fifo_wr),   32'd1);
    chk({tag, "_dat"},  32'(fifo_dat),  32'(d));
    chk({tag, "_type"}, 32'(fifo_type), 32'(oty));
    chk({tag, "_done"}, 32'(blk_done),  32'(done));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr"},    32'(fifo_wr),   32'd0);
    chk({tag, "_dat"},   32'(fifo_dat),  32'd0);
    chk({tag, "_type"},  32'(fifo_type), 32'd0);
    chk({tag, "_done"},  32'(blk_done),  32'd0);
    chk({tag, "_len"},   32'(blk_len),   32'd0);
    chk({tag, "_grant"}, 32'(grant),     32'd0);
    chk({tag, "_drop"},  32'(drop_cnt),  32'd0);
    chk({tag, "_trunc"}, 32'(trunc_cnt), 32'd0);
    chk({tag, "_ack"},   32'(rst_ack),   32'd0);
    chk({tag, "_frst"},  32'(fifo_rst),  32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    src_valid = '0;
    src_dat   = '0;
    src_type  = '0;
    fifo_full = 1'b0;
    rst_req   = 1'b0;

    // Reset state
    tick();
    tick();
    chk_all_zero("rst");
    chk("rst_rdy", 32'(src_ready), 32'd0);
    rst_n = 1'b1;

    // Single block on ch0
    word("s1_hdr", 0, T_HDR,  16'h1000, 4'b0001, T_HDR,  1'b0);
    word("s1_d1",  0, T_DATA, 16'h1001, 4'b0001, T_DATA, 1'b0);
    word("s1_d2",  0, T_DATA, 16'h1002, 4'b0001, T_DATA, 1'b0);
    word("s1_d3",  0, T_DATA, 16'h1003, 4'b0001, T_DATA, 1'b0);
    word("s1_end", 0, T_END,  16'h1004, 4'b0001, T_END,  1'b1);
    src_valid = '0;
    chk("s1_len",   32'(blk_len), 32'd5);
    chk("s1_grant", 32'(grant),   32'd0);
    tick();
    chk("s1_idle_wr",   32'(fifo_wr),  32'd0);
    chk("s1_idle_done", 32'(blk_done), 32'd0);

    // Stray DATA on ch3 while idle
    set_w(3, 1'b1, T_DATA, 16'h7777);
    #1;
    chk("stray_rdy", 32'(src_ready), 32'b1000);
    tick();
    chk("stray_wr",   32'(fifo_wr),  32'd0);
    chk("stray_drop", 32'(drop_cnt), 32'd1);
    src_valid = '0;

    // ch1 and ch2 headers together: ch1 first, no interleaving
    set_w(2, 1'b1, T_HDR, 16'h2200);
    word("s2_h1", 1, T_HDR,  16'h2100, 4'b0010, T_HDR,  1'b0);
    chk("s2_grant1", 32'(grant), 32'd1);
    word("s2_d1", 1, T_DATA, 16'h2101, 4'b0010, T_DATA, 1'b0);
    word("s2_e1", 1, T_END,  16'h2102, 4'b0010, T_END,  1'b1);
    src_valid[1] = 1'b0;
    chk("s2_len1", 32'(blk_len), 32'd3);
    word("s2_h2", 2, T_HDR,  16'h2200, 4'b0100, T_HDR,  1'b0);
    chk("s2_grant2", 32'(grant), 32'd2);
    word("s2_d2", 2, T_DATA, 16'h2201, 4'b0100, T_DATA, 1'b0);
    word("s2_e2", 2, T_END,  16'h2202, 4'b0100, T_END,  1'b1);
    src_valid = '0;

    // Truncation on ch3 (pointer now 3, so ch3 beats a waiting ch0)
    set_w(0, 1'b1, T_HDR, 16'h4000);
    word("s4_h", 3, T_HDR, 16'h3000, 4'b1000, T_HDR, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      word("s4_d", 3, T_DATA, 16'(16'h3000 + i), 4'b1000, T_DATA, 1'b0);
    end
    set_w(3, 1'b1, T_DATA, 16'h3007);
    #1;
    chk("s4_trunc_rdy", 32'(src_ready), 32'b0000);
    tick();
    chk("s4_trunc_wr",   32'(fifo_wr),   32'd1);
    chk("s4_trunc_dat",  32'(fifo_dat),  32'hDEAD);
    chk("s4_trunc_type", 32'(fifo_type), 32'(T_ERR));
    chk("s4_trunc_done", 32'(blk_done),  32'd1);
    chk("s4_trunc_len",  32'(blk_len),   32'd8);
    chk("s4_trunc_cnt",  32'(trunc_cnt), 32'd1);
    for (int i = 7; i <= 11; i++) begin
      set_w(3, 1'b1, (i == 11) ? T_END : T_DATA, 16'(16'h3000 + i));
      #1;
      chk("s4_drain_rdy", 32'(src_ready), 32'b1000);
      tick();
      chk("s4_drain_wr", 32'(fifo_wr), 32'd0);
    end
    src_valid[3] = 1'b0;

    // ch0 block with FIFO full for 4 cycles mid-block
    word("s3_h",  0, T_HDR,  16'h4000, 4'b0001, T_HDR,  1'b0);
    word("s3_d1", 0, T_DATA, 16'h4001, 4'b0001, T_DATA, 1'b0);
    fifo_full = 1'b1;
    set_w(0, 1'b1, T_DATA, 16'h4002);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("s3_full_rdy", 32'(src_ready), 32'b0000);
      tick();
      chk("s3_full_wr", 32'(fifo_wr), 32'd0);
    end
    chk("s3_len_hold", 32'(blk_len), 32'd8);
    fifo_full = 1'b0;
    word("s3_d2", 0, T_DATA, 16'h4002, 4'b0001, T_DATA, 1'b0);
    word("s3_e",  0, T_END,  16'h4003, 4'b0001, T_END,  1'b1);
    src_valid = '0;
    chk("s3_len", 32'(blk_len), 32'd4);

    // Reset request raised on word 2 of a ch1 block
    word("s5_h",  1, T_HDR,  16'h5000, 4'b0010, T_HDR,  1'b0);
    word("s5_d1", 1, T_DATA, 16'h5001, 4'b0010, T_DATA, 1'b0);
    rst_req = 1'b1;
    word("s5_d2", 1, T_DATA, 16'h5002, 4'b0010, T_DATA, 1'b0);
    word("s5_e",  1, T_END,  16'h5003, 4'b0010, T_END,  1'b1);
    chk("s5_frst1", 32'(fifo_rst), 32'd1);
    chk("s5_ack1",  32'(rst_ack),  32'd1);
    src_valid = '0;
    set_w(0, 1'b1, T_HDR, 16'h6000);
    set_w(3, 1'b1, T_HDR, 16'h6300);
    #1;
    chk("s5_rst_rdy1", 32'(src_ready), 32'b0000);
    tick();
    chk("s5_frst2", 32'(fifo_rst), 32'd0);
    chk("s5_ack2",  32'(rst_ack),  32'd1);
    chk("s5_rst_wr", 32'(fifo_wr), 32'd0);
    rst_req = 1'b0;
    #1;
    chk("s5_rst_rdy2", 32'(src_ready), 32'b0000);
    tick();
    chk("s5_ack3",  32'(rst_ack),  32'd0);
    chk("s5_frst3", 32'(fifo_rst), 32'd0);
    word("s5_h0", 0, T_HDR, 16'h6000, 4'b0001, T_HDR, 1'b0);
    chk("s5_grant0", 32'(grant), 32'd0);

    // rst_n low mid-block
    src_valid[3] = 1'b0;
    set_w(0, 1'b1, T_DATA, 16'h6001);
    rst_n = 1'b0;
    #1;
    chk("s6_rdy", 32'(src_ready), 32'b0000);
    tick();
    chk_all_zero("s6");
    rst_n     = 1'b1;
    src_valid = '0;
    #1;
    chk("s6_idle_rdy", 32'(src_ready), 32'b0000);
    tick();
    chk("s6_after_wr", 32'(fifo_wr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
